// File: rtl/x_mem_bridge_if.sv
// x_mem_bridge_if: core bus and TX byte stream between the core/UART side and x_mem_bridge
//  i_valid/i_rnw/i_addr/i_data : request from the core, held until o_accept
//  o_accept/o_data             : completion and read data
//  o_tx_valid/o_tx_data        : TX FIFO head offered to the UART
//  i_tx_ready                  : UART takes the head byte
interface x_mem_bridge_if;
    logic        i_valid;
    logic        i_rnw;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_accept;
    logic [31:0] o_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    modport slave (
        input  i_valid, i_rnw, i_addr, i_data, i_tx_ready,
        output o_accept, o_data, o_tx_valid, o_tx_data
    );
    modport master (
        output i_valid, i_rnw, i_addr, i_data, i_tx_ready,
        input  o_accept, o_data, o_tx_valid, o_tx_data
    );
endinterface

// File: rtl/x_mem_bridge.sv
// x_mem_bridge: word RAM plus UART TX FIFO and GPIO register behind the rv32i core bus
module x_mem_bridge #(
  parameter int    RAM_WORDS  = 1024,
  parameter string INIT_FILE  = "",
  parameter int    FIFO_DEPTH = 8,
  parameter int    GPIO_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  x_mem_bridge_if.slave     bus,
  output logic [GPIO_W-1:0] o_gpio
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
  typedef enum logic {IDLE, RD} state_t;
  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  state_t            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]       count;
  logic              is_per, is_tx, full, empty, wr_ok, push, pop, ram_we;
  logic [1:0]        sel;
  logic [AW-1:0]     idx;
  logic [31:0]       status, rd_val;
  logic              unused_addr;
  assign unused_addr = ^{bus.i_addr[30:AW+2], bus.i_addr[1:0]};
  always_comb begin
    is_per  = bus.i_addr[31];
    sel     = bus.i_addr[3:2];
    idx     = bus.i_addr[AW+1:2];
    count   = wr_q - rd_q;
    full    = count == FULL_CNT;
    empty   = count == '0;
    status  = {16'd0, 8'(count), 6'd0, empty, full};
    rd_val  = !is_per ? ram[idx] : sel == 2'd1 ? status : sel == 2'd2 ? 32'(gpio_q) : 32'd0;
    is_tx   = is_per && sel == 2'd0;
    wr_ok   = state_q == IDLE && bus.i_valid && !bus.i_rnw && !(is_tx && full);
    push    = wr_ok && is_tx;
    pop     = !empty && bus.i_tx_ready;
    ram_we  = wr_ok && !is_per;
    wr_d    = wr_q + {{PW{1'b0}}, push};
    rd_d    = rd_q + {{PW{1'b0}}, pop};
    gpio_d  = (wr_ok && is_per && sel == 2'd2) ? bus.i_data[GPIO_W-1:0] : gpio_q;
    state_d = (state_q == IDLE && bus.i_valid && bus.i_rnw) ? RD : IDLE;
    data_d  = (state_q == IDLE && bus.i_valid && bus.i_rnw) ? rd_val : data_q;
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      data_q  <= '0;
      gpio_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gpio_q  <= gpio_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (ram_we) ram[idx] <= bus.i_data;
    if (push) fifo_mem[wr_q[PW-1:0]] <= bus.i_data[7:0];
  end
  assign bus.o_accept   = i_nrst && (state_q == RD || wr_ok);
  assign bus.o_data     = data_q;
  assign bus.o_tx_valid = !empty;
  assign bus.o_tx_data  = empty ? 8'd0 : fifo_mem[rd_q[PW-1:0]];
  assign o_gpio         = gpio_q;
endmodule

// File: tb/tb_x_mem_bridge.sv
// tb_x_mem_bridge: directed self-checking bench for x_mem_bridge
module tb_x_mem_bridge;
    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] gpio;
    int         checks = 0;
    int         errors = 0;

    x_mem_bridge_if bus();

    x_mem_bridge #(.RAM_WORDS(1024), .INIT_FILE(""), .FIFO_DEPTH(8), .GPIO_W(8)) dut (
        .i_clk (clk),
        .i_nrst(nrst),
        .bus   (bus.slave),
        .o_gpio(gpio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        bus.i_valid = 1'b1;
        bus.i_rnw   = 1'b0;
        bus.i_addr  = a;
        bus.i_data  = d;
        @(negedge clk);
        chk({tag, "_acc"}, {31'd0, bus.o_accept}, 32'd1);
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.i_valid = 1'b1;
        bus.i_rnw   = 1'b1;
        bus.i_addr  = a;
        @(negedge clk);
        chk({tag, "_acc0"}, {31'd0, bus.o_accept}, 32'd0);
        step();
        @(negedge clk);
        chk({tag, "_acc1"}, {31'd0, bus.o_accept}, 32'd1);
        chk({tag, "_data"}, bus.o_data, exp);
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [7:0] first, input int n);
        bus.i_tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_byte"}, {24'd0, bus.o_tx_data}, 32'(first) + 32'(i));
        end
        @(negedge clk);
        chk({tag, "_empty"}, {23'd0, bus.o_tx_valid, bus.o_tx_data}, 32'd0);
        step();
        bus.i_tx_ready = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_rnw = 1'b0;
        bus.i_addr = '0;
        bus.i_data = '0;
        bus.i_tx_ready = 1'b0;
        #12;
        chk("rst_acc", {31'd0, bus.o_accept}, 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        chk("rst_tx", {23'd0, bus.o_tx_valid, bus.o_tx_data}, 32'd0);
        chk("rst_gpio", {24'd0, gpio}, 32'd0);
        step();
        nrst = 1'b1;
        step();
        // boot word placed in RAM, then a reset: it must survive and read back
        wr("w0", 32'h0, 32'h00500093);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
        rd("boot", 32'h0, 32'h00500093);
        // RAM write and alias
        wr("w40", 32'h40, 32'h12345678);
        rd("r40", 32'h40, 32'h12345678);
        rd("r40alias", 32'h40 + 32'd4096, 32'h12345678);
        rd("stat_empty", 32'h80000004, 32'h00000002);
        // fill FIFO, then stall
        for (int i = 0; i < 8; i++) wr("push", 32'h80000000, 32'h41 + 32'(i));
        rd("stat_full", 32'h80000004, 32'h00000801);
        bus.i_valid = 1'b1;
        bus.i_rnw   = 1'b0;
        bus.i_addr  = 32'h80000000;
        bus.i_data  = 32'h49;
        @(negedge clk);
        chk("stall0", {31'd0, bus.o_accept}, 32'd0);
        step();
        @(negedge clk);
        chk("stall1", {31'd0, bus.o_accept}, 32'd0);
        step();
        bus.i_tx_ready = 1'b1;
        @(negedge clk);
        chk("head41", {23'd0, bus.o_tx_valid, bus.o_tx_data}, 32'h141);
        chk("stall_pop", {31'd0, bus.o_accept}, 32'd0);
        step();
        bus.i_tx_ready = 1'b0;
        @(negedge clk);
        chk("unstall", {31'd0, bus.o_accept}, 32'd1);
        step();
        bus.i_valid = 1'b0;
        rd("stat_refull", 32'h80000004, 32'h00000801);
        drain("drain8", 8'h42, 8);
        // simultaneous push and pop
        wr("p10", 32'h80000000, 32'h10);
        wr("p11", 32'h80000000, 32'h11);
        bus.i_tx_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_rnw   = 1'b0;
        bus.i_addr  = 32'h80000000;
        bus.i_data  = 32'h12;
        @(negedge clk);
        chk("pp_acc", {31'd0, bus.o_accept}, 32'd1);
        chk("pp_head", {24'd0, bus.o_tx_data}, 32'h10);
        step();
        bus.i_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        rd("stat_pp", 32'h80000004, 32'h00000200);
        drain("drain_pp", 8'h11, 2);
        // GPIO and unmapped / TXDATA reads
        wr("gpio", 32'h80000008, 32'hFFFFFFA5);
        chk("gpio_out", {24'd0, gpio}, 32'hA5);
        rd("gpio_rd", 32'h80000008, 32'h000000A5);
        rd("unmapped", 32'h8000000C, 32'h0);
        rd("txdata_rd", 32'h80000000, 32'h0);
        wr("stat_wr", 32'h80000004, 32'hFFFFFFFF);
        rd("stat_keep", 32'h80000004, 32'h00000002);
        // reset while in RD with FIFO non-empty
        wr("q1", 32'h80000000, 32'h77);
        wr("q2", 32'h80000000, 32'h78);
        bus.i_valid = 1'b1;
        bus.i_rnw   = 1'b1;
        bus.i_addr  = 32'h40;
        step();
        nrst = 1'b0;
        #1;
        chk("mid_acc", {31'd0, bus.o_accept}, 32'd0);
        chk("mid_tx", {23'd0, bus.o_tx_valid, bus.o_tx_data}, 32'd0);
        chk("mid_gpio", {24'd0, gpio}, 32'd0);
        chk("mid_data", bus.o_data, 32'd0);
        bus.i_valid = 1'b0;
        step();
        nrst = 1'b1;
        step();
        chk("post_tx", {31'd0, bus.o_tx_valid}, 32'd0);
        rd("ram_kept", 32'h40, 32'h12345678);
        rd("stat_flushed", 32'h80000004, 32'h00000002);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
